// File: rtl/pattern_checker_if.sv
// rtl/pattern_checker_if.sv - serial pattern checker signal bundle
//
// Purpose: groups the serial input and the checker status outputs.
// Signals:
//   pattern_in  - serial bit from the pattern generator (master drives)
//   locked      - checker is phase-locked (slave drives)
//   bit_err     - one-cycle pulse per mismatching bit while locked
//   match_pulse - one-cycle pulse per error-free locked period
//   err_count   - saturating total mismatch count
interface pattern_checker_if #(
  parameter int ERR_CNT_W = 16
);
  logic                 pattern_in;
  logic                 locked;
  logic                 bit_err;
  logic                 match_pulse;
  logic [ERR_CNT_W-1:0] err_count;

  modport master (
    output pattern_in,
    input  locked, bit_err, match_pulse, err_count
  );

  modport slave (
    input  pattern_in,
    output locked, bit_err, match_pulse, err_count
  );
endinterface

// File: rtl/pattern_checker.sv
// rtl/pattern_checker.sv - serial pattern lock and bit-error checker
//
// Purpose: hunts for a repeating PATTERN on a 1-bit stream, locks onto its
// phase, then compares every bit against the expected one, counting errors
// and dropping lock when too many errors land in one period.
// Ports:
//   clk - clock, one bit consumed per rising edge
//   rst - synchronous active-high reset
//   bus - pattern_checker_if slave: pattern_in in; locked, bit_err,
//         match_pulse, err_count out (all registered)
module pattern_checker #(
  parameter int                     PATTERN_LEN    = 8,
  parameter logic [PATTERN_LEN-1:0] PATTERN        = 8'b1011_0010,
  parameter int                     LOCK_ERR_LIMIT = 4,
  parameter int                     ERR_CNT_W      = 16
) (
  input  logic                clk,
  input  logic                rst,
  pattern_checker_if.slave    bus
);

  localparam int IDX_W  = $clog2(PATTERN_LEN);
  localparam int FILL_W = $clog2(PATTERN_LEN + 1);
  localparam int PE_W   = $clog2(PATTERN_LEN + 2);

  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(PATTERN_LEN - 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PATTERN_LEN);
  localparam logic [FILL_W-1:0] FILL_NEAR = FILL_W'(PATTERN_LEN - 1);

  typedef enum logic {S_HUNT, S_LOCK} state_t;

  state_t                 state_q, state_d;
  logic [PATTERN_LEN-2:0] sr_q, sr_d;
  logic [FILL_W-1:0]      fill_q, fill_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [PE_W-1:0]        per_err_q, per_err_d;
  logic                   bit_err_q, bit_err_d;
  logic                   match_q, match_d;
  logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;

  logic [PATTERN_LEN-1:0] window;
  logic                   exp_bit;
  logic                   mismatch;
  logic                   limit_hit;

  // The window includes the bit arriving on this edge, so a match is seen
  // on the same edge that samples the final pattern bit.
  assign window    = {sr_q, bus.pattern_in};
  assign exp_bit   = PATTERN[IDX_LAST - idx_q];
  assign mismatch  = (bus.pattern_in != exp_bit);
  // Integer compare so a limit larger than the counter range never aliases.
  assign limit_hit = mismatch && ((int'(per_err_q) + 1) == LOCK_ERR_LIMIT);

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    fill_d    = fill_q;
    idx_d     = idx_q;
    per_err_d = per_err_q;
    err_cnt_d = err_cnt_q;
    bit_err_d = 1'b0;
    match_d   = 1'b0;

    case (state_q)
      S_HUNT: begin
        sr_d   = window[PATTERN_LEN-2:0];
        fill_d = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
        if ((fill_q >= FILL_NEAR) && (window == PATTERN)) begin
          state_d   = S_LOCK;
          idx_d     = '0;
          per_err_d = '0;
        end
      end

      S_LOCK: begin
        idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        if (mismatch) begin
          bit_err_d = 1'b1;
          per_err_d = per_err_q + PE_W'(1);
          if (err_cnt_q != '1) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
          end
        end
        if (idx_q == IDX_LAST) begin
          match_d   = (per_err_q == '0) && !mismatch;
          per_err_d = '0;
        end
        // Dropping lock restarts the hunt from an empty window so relock
        // needs a full period of fresh bits.
        if (limit_hit) begin
          state_d   = S_HUNT;
          fill_d    = '0;
          sr_d      = '0;
          per_err_d = '0;
        end
      end

      default: state_d = S_HUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_HUNT;
      sr_q      <= '0;
      fill_q    <= '0;
      idx_q     <= '0;
      per_err_q <= '0;
      bit_err_q <= 1'b0;
      match_q   <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      fill_q    <= fill_d;
      idx_q     <= idx_d;
      per_err_q <= per_err_d;
      bit_err_q <= bit_err_d;
      match_q   <= match_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.locked      = (state_q == S_LOCK);
  assign bus.bit_err     = bit_err_q;
  assign bus.match_pulse = match_q;
  assign bus.err_count   = err_cnt_q;

endmodule

// File: tb/tb_pattern_checker.sv
// tb/tb_pattern_checker.sv - directed self-checking bench for pattern_checker
module tb_pattern_checker;

  localparam logic [7:0] P = 8'b1011_0010;

  logic clk = 1'b0;
  logic rst0;
  logic rst1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pattern_checker_if #(.ERR_CNT_W(16)) if0 ();
  pattern_checker_if #(.ERR_CNT_W(4))  if1 ();

  pattern_checker u_dut0 (
    .clk (clk),
    .rst (rst0),
    .bus (if0)
  );

  pattern_checker #(
    .LOCK_ERR_LIMIT (9),
    .ERR_CNT_W      (4)
  ) u_dut1 (
    .clk (clk),
    .rst (rst1),
    .bus (if1)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick0(input logic b);
    if0.pattern_in = b;
    @(posedge clk);
    #1;
  endtask

  task automatic tick1(input logic b);
    if1.pattern_in = b;
    @(posedge clk);
    #1;
  endtask

  task automatic reset0();
    rst0 = 1'b1;
    if0.pattern_in = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
    rst0 = 1'b0;
  endtask

  initial begin
    rst0 = 1'b1;
    rst1 = 1'b1;
    if0.pattern_in = 1'b0;
    if1.pattern_in = 1'b0;

    // Reset held for 3 cycles with random input
    for (int c = 0; c < 3; c++) begin
      if0.pattern_in = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      chk("rst_locked", 16'(if0.locked), 16'd0);
      chk("rst_bit_err", 16'(if0.bit_err), 16'd0);
      chk("rst_match", 16'(if0.match_pulse), 16'd0);
      chk("rst_err_count", if0.err_count, 16'd0);
      chk("rst_locked_dut1", 16'(if1.locked), 16'd0);
    end

    // Offset start at index 3: lock after edge 13
    reset0();
    for (int k = 0; k < 13; k++) begin
      tick0(P[7 - ((3 + k) % 8)]);
      chk("ofs_locked", 16'(if0.locked), 16'(k == 12));
      chk("ofs_bit_err", 16'(if0.bit_err), 16'd0);
    end
    for (int i = 0; i < 8; i++) begin
      tick0(P[7 - i]);
      chk("ofs_match", 16'(if0.match_pulse), 16'(i == 7));
    end

    // Clean aligned stream then single error in 3rd locked period
    reset0();
    for (int i = 0; i < 8; i++) begin
      tick0(P[7 - i]);
      chk("aln_locked", 16'(if0.locked), 16'(i == 7));
    end
    for (int per = 1; per <= 4; per++) begin
      for (int i = 0; i < 8; i++) begin
        logic b;
        b = P[7 - i];
        if (per == 3 && i == 2) b = ~b;
        tick0(b);
        chk("aln_bit_err", 16'(if0.bit_err), 16'(per == 3 && i == 2));
        chk("aln_match", 16'(if0.match_pulse), 16'(i == 7 && per != 3));
        chk("aln_locked_hold", 16'(if0.locked), 16'd1);
        chk("aln_err_count", if0.err_count, (per > 3 || (per == 3 && i >= 2)) ? 16'd1 : 16'd0);
      end
    end

    // Loss of lock after 4 errors, then relock
    reset0();
    for (int i = 0; i < 8; i++) tick0(P[7 - i]);
    chk("los_locked", 16'(if0.locked), 16'd1);
    for (int i = 0; i < 8; i++) tick0(P[7 - i]);
    chk("los_match", 16'(if0.match_pulse), 16'd1);
    for (int i = 0; i < 4; i++) begin
      tick0(~P[7 - i]);
      chk("los_bit_err", 16'(if0.bit_err), 16'd1);
      chk("los_locked_fall", 16'(if0.locked), 16'(i != 3));
    end
    chk("los_err_count", if0.err_count, 16'd4);
    for (int k = 0; k < 12; k++) begin
      tick0(P[7 - ((4 + k) % 8)]);
      chk("rel_locked", 16'(if0.locked), 16'(k == 11));
      chk("rel_bit_err", 16'(if0.bit_err), 16'd0);
    end
    for (int i = 0; i < 8; i++) begin
      tick0(P[7 - i]);
      chk("rel_match", 16'(if0.match_pulse), 16'(i == 7));
    end
    chk("rel_err_count", if0.err_count, 16'd4);

    // Saturation with 4-bit counter and limit 9, then mid-op reset
    if1.pattern_in = 1'b0;
    @(posedge clk);
    #1;
    rst1 = 1'b0;
    for (int i = 0; i < 8; i++) tick1(P[7 - i]);
    chk("sat_locked", 16'(if1.locked), 16'd1);
    for (int n = 0; n < 24; n++) begin
      tick1(~P[7 - (n % 8)]);
      chk("sat_bit_err", 16'(if1.bit_err), 16'd1);
      chk("sat_locked_hold", 16'(if1.locked), 16'd1);
      chk("sat_match", 16'(if1.match_pulse), 16'd0);
      chk("sat_err_count", 16'(if1.err_count), (n + 1 > 15) ? 16'd15 : 16'(n + 1));
    end
    rst1 = 1'b1;
    if1.pattern_in = 1'b1;
    @(posedge clk);
    #1;
    rst1 = 1'b0;
    chk("mrst_err_count", 16'(if1.err_count), 16'd0);
    chk("mrst_locked", 16'(if1.locked), 16'd0);
    chk("mrst_bit_err", 16'(if1.bit_err), 16'd0);
    for (int i = 0; i < 8; i++) begin
      tick1(P[7 - i]);
      chk("mrst_relock", 16'(if1.locked), 16'(i == 7));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pattern_checker.md
# pattern_checker

Serial receive-side checker for the bit stream produced by the pattern generator. It hunts for the known repeating pattern on a 1-bit input and locks onto its phase. Once locked, it compares every incoming bit against the expected bit, counts errors and reports loss of lock. It sits at the far end of the generator's `pattern_out` line and serves as the self-check for link and bring-up benches.

## Interface
- `PATTERN_LEN`, 8: bits per pattern period; must be ≥ 2.
- `PATTERN`, 8'b1011_0010: the pattern, transmitted MSB first. It must not equal any nontrivial rotation of itself.
- `LOCK_ERR_LIMIT`, 4: number of errors within one period that forces loss of lock. Any value > `PATTERN_LEN` disables loss of lock.
- `ERR_CNT_W`, 16: width of the error counter.
- `clk` in 1: single clock. One pattern bit is sampled per rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `pattern_in` in 1: serial bit from the generator.
- `locked` out 1: high while phase-locked.
- `bit_err` out 1: one-cycle pulse for each mismatching bit while locked.
- `match_pulse` out 1: one-cycle pulse at the end of each error-free locked period.
- `err_count` out `ERR_CNT_W`: total mismatches since reset. Saturates at all-ones.

## Operation
- **State machine:** two states, HUNT and LOCK. Reset enters HUNT.
- **HUNT:**
  - Every cycle: `sr <= {sr[PATTERN_LEN-2:0], pattern_in}` and `fill` increments, saturating at `PATTERN_LEN`.
  - When the incoming bit completes a full window (`fill` ≥ `PATTERN_LEN-1` before the edge) and `{sr[PATTERN_LEN-2:0], pattern_in} == PATTERN`: go to LOCK, set `idx <= 0`, clear `per_err`.
  - `bit_err`, `match_pulse` and `err_count` updates are suppressed in HUNT.
- **LOCK:**
  - Expected bit is `PATTERN[PATTERN_LEN-1-idx]`. `idx` wraps from `PATTERN_LEN-1` to 0.
  - On mismatch: `bit_err <= 1`, `err_count` increments (saturating), `per_err` increments.
  - At `idx == PATTERN_LEN-1`: `match_pulse <= 1` only if `per_err` is 0 and the current bit matched. `per_err` is cleared for the next period.
  - When a mismatch brings the period's error count to `LOCK_ERR_LIMIT`:
    - Go to HUNT and clear `fill`, `sr` and `per_err`.
    - `bit_err` still pulses and `err_count` still increments on that same edge.
- `err_count` is cleared only by `rst`. It is retained across loss of lock and relock.
- **Reset mid-operation:** all state and outputs clear on the next edge, regardless of state, and the block returns to HUNT.

## Timing
- All outputs are registered. Reset values: `locked`=0, `bit_err`=0, `match_pulse`=0, `err_count`=0.
- **Lock latency:** `locked` is high in the cycle after the edge that samples the last bit of the first matching window. For a clean aligned stream starting at the first edge after `rst` falls, that is 8 edges with the defaults.
- **Bit latency:** `bit_err` and `match_pulse` are high for exactly one cycle, the cycle after the edge that sampled the offending or final bit.
- **Loss of lock:** `locked` falls in the same cycle as the `bit_err` pulse of the limit-reaching error.
- **Relock:** after loss of lock, a full `PATTERN_LEN` fresh bits are required before the next compare. Worst-case relock on a clean stream is `2*PATTERN_LEN-1` edges.
- **No bit enable:** a bit is consumed every edge while `rst` is low.

## Test plan
All scenarios use default parameters unless stated. Default pattern bits, MSB first: 1,0,1,1,0,0,1,0.
- **Reset:** hold `rst` high for 3 cycles with random `pattern_in` → all outputs 0 throughout, `locked` stays 0.
- **Clean aligned stream:** start the bit sequence right after reset release → `locked` rises after edge 8, `match_pulse` pulses every 8 cycles, `bit_err` never pulses, `err_count` stays 0.
- **Offset start:** stream begins at bit index 3 (1,0,0,1,0,1,0,1,…) → `locked` rises after edge 13, then `match_pulse` every 8 cycles.
- **Single error while locked:** flip one bit in the 3rd locked period →
  - one `bit_err` pulse and `err_count`=1;
  - no `match_pulse` for that period;
  - `locked` stays 1 and `match_pulse` resumes the next period.
- **Loss and relock:** invert 4 consecutive bits in one period, then return to the clean aligned stream →
  - `locked` falls with the 4th `bit_err` pulse and `err_count`=4;
  - `locked` rises again within 15 edges;
  - `err_count` holds 4 after relock.
- **Saturation and mid-op reset:** set `ERR_CNT_W`=4 and `LOCK_ERR_LIMIT`=9, lock, then send 3 inverted periods (24 errors) →
  - `err_count` reaches 15 and holds, `locked` stays 1;
  - then pulse `rst` for 1 cycle → `err_count`=0, `locked`=0, and the checker relocks 8 edges after clean aligned input resumes.
